minesweeper_control: RTL

Game-state controller for the 8x8 minesweeper board. Places mines with an LFSR, tracks the cursor, and applies flag/step commands from debounced push-buttons. Drives the four 64-bit tile maps consumed by the board renderer, plus a game-state code for the top level. Tile index n maps to column n[2:0] and row n[5:3]; tile 0 is top-left.

---
 rtl/minesweeper_control.sv | 137 +++++++++++++
 1 files changed

// File: rtl/minesweeper_control.sv
// rtl/minesweeper_control.sv - 8x8 minesweeper game-state controller (mine placement, cursor, flag/step)
// Optional: define CURSOR_WRAP_EN to make cursor moves wrap within the row/column instead of saturating.
module minesweeper_control #(
    parameter int          MINE_COUNT = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_flag,
    input  logic        btn_step,
    output logic [63:0] mineMap,
    output logic [63:0] flagMap,
    output logic [63:0] stepMap,
    output logic [63:0] posMap,
    output logic [1:0]  game_state
);

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [5:0] MINE_TARGET = 6'(MINE_COUNT);

    typedef enum logic [1:0] {
        ST_GEN  = 2'b00,
        ST_PLAY = 2'b01,
        ST_LOST = 2'b10,
        ST_WON  = 2'b11
    } state_t;

    state_t      state, state_nx;
    logic [15:0] lfsr, lfsr_nx;
    logic [5:0]  pos, pos_nx;
    logic [5:0]  placed, placed_nx;
    logic [63:0] mine_map, mine_nx;
    logic [63:0] flag_map, flag_nx;
    logic [63:0] step_map, step_nx;
    logic [63:0] pos_map;
    logic [5:0]  btn_now, btn_prev, press;
    logic [2:0]  row, col;

    // Bit order doubles as priority: step > flag > up > down > left > right
    assign btn_now = {btn_step, btn_flag, btn_up, btn_down, btn_left, btn_right};
    assign press   = btn_now & ~btn_prev;
    assign row     = pos[5:3];
    assign col     = pos[2:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_GEN;
            lfsr     <= LFSR_SEED;
            pos      <= 6'd0;
            placed   <= 6'd0;
            mine_map <= 64'd0;
            flag_map <= 64'd0;
            step_map <= 64'd0;
            pos_map  <= 64'd1;
            btn_prev <= 6'd0;
        end else begin
            state    <= state_nx;
            lfsr     <= lfsr_nx;
            pos      <= pos_nx;
            placed   <= placed_nx;
            mine_map <= mine_nx;
            flag_map <= flag_nx;
            step_map <= step_nx;
            pos_map  <= 64'd1 << pos_nx;
            btn_prev <= btn_now;
        end
    end

    always_comb begin
        state_nx  = state;
        lfsr_nx   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        pos_nx    = pos;
        placed_nx = placed;
        mine_nx   = mine_map;
        flag_nx   = flag_map;
        step_nx   = step_map;
        case (state)
            ST_GEN: begin
                if (placed == MINE_TARGET) begin
                    state_nx = ST_PLAY;
                end else if (!mine_map[lfsr[5:0]]) begin
                    mine_nx[lfsr[5:0]] = 1'b1;
                    placed_nx          = placed + 6'd1;
                end
            end
            ST_PLAY: begin
                // A fully uncovered board wins before any press is considered
                if (&(step_map | mine_map)) begin
                    state_nx = ST_WON;
                end else if (press[5]) begin
                    if (!flag_map[pos] && !step_map[pos]) begin
                        step_nx[pos] = 1'b1;
                        if (mine_map[pos]) begin
                            step_nx  = step_map | mine_map;
                            state_nx = ST_LOST;
                        end
                    end
                end else if (press[4]) begin
                    if (!step_map[pos]) flag_nx[pos] = ~flag_map[pos];
                end else if (press[3]) begin
                    if (WRAP || row != 3'd0) pos_nx = {row - 3'd1, col};
                end else if (press[2]) begin
                    if (WRAP || row != 3'd7) pos_nx = {row + 3'd1, col};
                end else if (press[1]) begin
                    if (WRAP || col != 3'd0) pos_nx = {row, col - 3'd1};
                end else if (press[0]) begin
                    if (WRAP || col != 3'd7) pos_nx = {row, col + 3'd1};
                end
            end
            default: begin
                if (press[5]) begin
                    mine_nx   = 64'd0;
                    flag_nx   = 64'd0;
                    step_nx   = 64'd0;
                    placed_nx = 6'd0;
                    state_nx  = ST_GEN;
                end
            end
        endcase
    end

    assign mineMap    = mine_map;
    assign flagMap    = flag_map;
    assign stepMap    = step_map;
    assign posMap     = pos_map;
    assign game_state = state;

endmodule
